// File: rtl/rr_arbiter_8_pkg.sv
// Shared constants, state encoding and helpers for the 8-way round-robin arbiter.
// Imported by the interface, the pick sub-module and the top.
package rr_arbiter_8_pkg;

  localparam int N   = 8;
  localparam int IDW = 3;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  function automatic logic [IDW-1:0] inc_mod8(input logic [IDW-1:0] v);
    return v + IDW'(1);
  endfunction

endpackage

// File: rtl/rr_arbiter_8_if.sv
// Request/grant bundle between the requesters (master) and the arbiter (slave).
interface rr_arbiter_8_if;
  import rr_arbiter_8_pkg::*;

  logic [N-1:0]   req;
  logic [N-1:0]   gnt;
  logic           gnt_valid;
  logic [IDW-1:0] gnt_id;
  logic           preempt;

  modport master (output req, input gnt, gnt_valid, gnt_id, preempt);
  modport slave  (input req, output gnt, gnt_valid, gnt_id, preempt);

endinterface

// File: rtl/rr_arbiter_8_pick8.sv
// Combinational round-robin pick: rotate req so ptr lands at bit 0,
// fixed-priority encode (bit 0 highest), then add ptr back modulo 8.
module rr_pick8
  import rr_arbiter_8_pkg::*;
(
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic           valid,
  output logic [IDW-1:0] id
);

  logic [N-1:0]   rot;
  logic [IDW-1:0] off;

  always_comb begin
    rot = '0;
    for (int i = 0; i < N; i++) begin
      rot[i] = req[ptr + IDW'(i)];
    end
    off = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) off = IDW'(i);
    end
    valid = |req;
    id    = off + ptr;
  end

endmodule

// File: rtl/rr_arbiter_8.sv
// Round-robin arbiter for 8 requesters with registered one-hot grant,
// hold-until-release ownership and an optional hold-timeout preemption.
module rr_arbiter_8
  import rr_arbiter_8_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int CNTW     = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  rr_arbiter_8_if.slave   bus
);

  localparam logic [0:0]      ST_IDLE  = IDLE;
  localparam logic [0:0]      ST_GRANT = GRANT;
  localparam logic [CNTW-1:0] HOLD_MAX = CNTW'(MAX_HOLD);
  localparam logic [N-1:0]    ONE      = N'(1);

  logic [0:0]      state;
  logic [IDW-1:0]  ptr;
  logic [CNTW-1:0] hold_cnt;
  logic [N-1:0]    gnt_r;
  logic            valid_r;
  logic [IDW-1:0]  id_r;
  logic            preempt_r;

  logic            pick_valid;
  logic [IDW-1:0]  pick_id;
  logic            owner_req;
  logic            timeout;

  rr_pick8 u_pick (
    .req   (bus.req),
    .ptr   (ptr),
    .valid (pick_valid),
    .id    (pick_id)
  );

  // Timeout only bites when somebody other than the owner is waiting.
  always_comb begin
    owner_req = bus.req[id_r];
    timeout   = (MAX_HOLD != 0) && (hold_cnt == HOLD_MAX) && (|(bus.req & ~gnt_r));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      hold_cnt  <= '0;
      gnt_r     <= '0;
      valid_r   <= 1'b0;
      id_r      <= '0;
      preempt_r <= 1'b0;
    end else begin
      preempt_r <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            state    <= ST_GRANT;
            gnt_r    <= ONE << pick_id;
            valid_r  <= 1'b1;
            id_r     <= pick_id;
            hold_cnt <= CNTW'(1);
          end
        end
        default: begin
          if (!owner_req || timeout) begin
            // Release always detours through IDLE; ptr moves past the owner.
            state     <= ST_IDLE;
            gnt_r     <= '0;
            valid_r   <= 1'b0;
            id_r      <= '0;
            hold_cnt  <= '0;
            ptr       <= inc_mod8(id_r);
            preempt_r <= owner_req;
          end else if ((MAX_HOLD != 0) && (hold_cnt != HOLD_MAX)) begin
            hold_cnt <= hold_cnt + CNTW'(1);
          end
        end
      endcase
    end
  end

  assign bus.gnt       = gnt_r;
  assign bus.gnt_valid = valid_r;
  assign bus.gnt_id    = id_r;
  assign bus.preempt   = preempt_r;

endmodule
